// File: rtl/tl_pkg.sv
// TileLink-UL A-channel shared types and helpers.
// Widths, opcodes and beat-count math.
package tl_pkg;

  localparam int ADDR_W   = 26;
  localparam int SOURCE_W = 5;
  localparam int SIZE_W   = 4;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 8;
  localparam int MASK_W   = DATA_W / 8;

  localparam int unsigned BEAT_BYTES = DATA_W / 8;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGIC       = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] HINT        = 3'd5;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic [ADDR_W-1:0]   address;
    logic [MASK_W-1:0]   mask;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
  } tl_a_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rep_state_e;

  function automatic logic has_data(
    input logic [2:0] op
  );
    return (op == PUT_FULL) ||
           (op == PUT_PARTIAL);
  endfunction

  // Message length in beats; sub-beat writes
  // still occupy one beat.
  function automatic logic [CNT_W:0] num_beats(
    input logic [SIZE_W-1:0] size,
    input logic [2:0]        op
  );
    int unsigned bytes;
    int unsigned beats;
    bytes = 32'd1 << size;
    beats = bytes / BEAT_BYTES;
    if (!has_data(op) || beats == 0)
      beats = 1;
    return beats[CNT_W:0];
  endfunction

endpackage

// File: rtl/tl_a_repeater_if.sv
// A-channel valid/ready bundle.
// Master drives valid/bits, slave drives ready.
interface tl_a_if;
  import tl_pkg::*;

  logic  valid;
  logic  ready;
  tl_a_t bits;

  modport master (
    output valid,
    output bits,
    input  ready
  );

  modport slave (
    input  valid,
    input  bits,
    output ready
  );
endinterface

// File: rtl/tl_beat_counter.sv
// Beat position tracker for TileLink bursts.
// Shared by A- and D-channel stages.
module tl_beat_counter
  import tl_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fire_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic [2:0]        opcode_i,
  output logic              first_o,
  output logic              last_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   beats;

  assign beats   = num_beats(size_i, opcode_i);
  assign first_o = (cnt_q == '0);
  assign last_o  = ({1'b0, cnt_q} ==
                    (beats - (CNT_W+1)'(1)));
  assign cnt_o   = cnt_q;

  // Advance on each beat, wrap after the last.
  always_comb begin
    cnt_d = cnt_q;
    if (fire_i)
      cnt_d = last_o ? '0
                     : cnt_q + CNT_W'(1);
  end

  // Counter register, sync active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tl_a_repeater.sv
// Single-entry A-channel repeater.
// Pass-through unless downstream asks to replay.
module tl_a_repeater
  import tl_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  tl_a_if.slave            enq,
  tl_a_if.master           deq,
  input  logic             repeat_i,
  output logic             full_o,
  output logic             deq_first_o,
  output logic             deq_last_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  rep_state_e state_q;
  rep_state_e state_d;
  tl_a_t      saved_q;
  tl_a_t      saved_d;
  logic       enq_fire;
  logic       deq_fire;

  assign full_o    = (state_q == ST_FULL);
  assign enq.ready = deq.ready & ~full_o;
  assign deq.valid = enq.valid | full_o;
  assign deq.bits  = full_o ? saved_q
                            : enq.bits;
  assign enq_fire  = enq.valid & enq.ready;
  assign deq_fire  = deq.valid & deq.ready;

  // Capture on a repeated pass-through beat,
  // release on the first non-repeat beat.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (enq_fire && repeat_i) begin
          state_d = ST_FULL;
          saved_d = enq.bits;
        end
      end
      ST_FULL: begin
        if (deq_fire && !repeat_i)
          state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Occupancy register, sync active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n)
      state_q <= ST_EMPTY;
    else
      state_q <= state_d;
  end

  // Saved payload; only meaningful while full.
  always_ff @(posedge clock) begin
    saved_q <= saved_d;
  end

  tl_beat_counter u_beats (
    .clock    (clock),
    .reset_n  (reset_n),
    .fire_i   (deq_fire),
    .size_i   (deq.bits.size),
    .opcode_i (deq.bits.opcode),
    .first_o  (deq_first_o),
    .last_o   (deq_last_o),
    .cnt_o    (beat_cnt_o)
  );

endmodule

// File: tb/tb_tl_a_repeater.sv
// Directed bench for tl_a_repeater.
// Scenario tasks with inline expected values.
module tb_tl_a_repeater;
  import tl_pkg::*;

  logic             clock;
  logic             reset_n;
  logic             repeat_i;
  logic             full_o;
  logic             deq_first_o;
  logic             deq_last_o;
  logic [CNT_W-1:0] beat_cnt_o;

  int errors;
  int checks;
  int hs_cnt;

  tl_a_if enq_if ();
  tl_a_if deq_if ();

  tl_a_repeater dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enq         (enq_if),
    .deq         (deq_if),
    .repeat_i    (repeat_i),
    .full_o      (full_o),
    .deq_first_o (deq_first_o),
    .deq_last_o  (deq_last_o),
    .beat_cnt_o  (beat_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock)
    if (deq_if.valid && deq_if.ready)
      hs_cnt++;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(
    input logic [2:0]        op,
    input logic [SIZE_W-1:0] sz,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] dat
  );
    enq_if.bits.opcode  = op;
    enq_if.bits.param   = 3'd0;
    enq_if.bits.size    = sz;
    enq_if.bits.source  = 5'd3;
    enq_if.bits.address = addr;
    enq_if.bits.mask    = 4'hf;
    enq_if.bits.data    = dat;
    enq_if.bits.corrupt = 1'b0;
  endtask

  task automatic test_reset;
    reset_n        = 1'b0;
    repeat_i       = 1'b0;
    enq_if.valid   = 1'b1;
    deq_if.ready   = 1'b1;
    set_req(GET, 4'd2, 26'h0, 32'h0);
    tick;
    tick;
    reset_n = 1'b1;
    #1;
    checks++;
    if (full_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_full got=%b exp=0",
               full_o);
    end
    checks++;
    if (beat_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0",
               beat_cnt_o);
    end
    checks++;
    if (deq_first_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_first got=%b exp=1",
               deq_first_o);
    end
    checks++;
    if (deq_if.valid !== 1'b1 ||
        enq_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs got=%b%b exp=11",
               deq_if.valid, enq_if.ready);
    end
  endtask

  task automatic test_pass;
    set_req(GET, 4'd2, 26'h0001000, 32'h55);
    enq_if.valid = 1'b1;
    deq_if.ready = 1'b1;
    repeat_i     = 1'b0;
    #1;
    checks++;
    if (deq_if.bits !== enq_if.bits) begin
      errors++;
      $display("FAIL pass_bits got=%h exp=%h",
               deq_if.bits, enq_if.bits);
    end
    checks++;
    if (deq_first_o !== 1'b1 ||
        deq_last_o !== 1'b1) begin
      errors++;
      $display("FAIL pass_fl got=%b%b exp=11",
               deq_first_o, deq_last_o);
    end
    tick;
    checks++;
    if (full_o !== 1'b0) begin
      errors++;
      $display("FAIL pass_full got=%b exp=0",
               full_o);
    end
  endtask

  task automatic test_backpressure;
    int h0;
    h0 = hs_cnt;
    set_req(GET, 4'd2, 26'h0001040, 32'h0);
    enq_if.valid = 1'b1;
    deq_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (enq_if.ready !== 1'b0 ||
          deq_if.valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall%0d got=%b%b exp=01",
                 i, enq_if.ready, deq_if.valid);
      end
      tick;
    end
    deq_if.ready = 1'b1;
    #1;
    checks++;
    if (enq_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got=%b exp=1",
               enq_if.ready);
    end
    tick;
    enq_if.valid = 1'b0;
    #1;
    checks++;
    if (deq_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle got=%b exp=0",
               deq_if.valid);
    end
    checks++;
    if (hs_cnt - h0 !== 1) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=1",
               hs_cnt - h0);
    end
  endtask

  task automatic test_repeat;
    set_req(GET, 4'd2, 26'h0002000, 32'h0);
    enq_if.valid = 1'b1;
    deq_if.ready = 1'b1;
    repeat_i     = 1'b1;
    #1;
    checks++;
    if (full_o !== 1'b0 ||
        deq_if.bits.address !== 26'h0002000) begin
      errors++;
      $display("FAIL rep_first got=%b/%h exp=0/2000",
               full_o, deq_if.bits.address);
    end
    tick;
    enq_if.bits.address = 26'h0003000;
    for (int i = 0; i < 3; i++) begin
      if (i == 2)
        repeat_i = 1'b0;
      #1;
      checks++;
      if (full_o !== 1'b1 ||
          enq_if.ready !== 1'b0) begin
        errors++;
        $display("FAIL rep_full%0d got=%b%b exp=10",
                 i, full_o, enq_if.ready);
      end
      checks++;
      if (deq_if.bits.address !== 26'h0002000) begin
        errors++;
        $display("FAIL rep_addr%0d got=%h exp=2000",
                 i, deq_if.bits.address);
      end
      checks++;
      if (deq_first_o !== 1'b1 ||
          deq_last_o !== 1'b1) begin
        errors++;
        $display("FAIL rep_fl%0d got=%b%b exp=11",
                 i, deq_first_o, deq_last_o);
      end
      tick;
    end
    checks++;
    if (full_o !== 1'b0 ||
        deq_if.bits.address !== 26'h0003000) begin
      errors++;
      $display("FAIL rep_exit got=%b/%h exp=0/3000",
               full_o, deq_if.bits.address);
    end
    tick;
  endtask

  task automatic test_burst;
    logic [3:0] fl_exp [4];
    fl_exp[0] = 4'b10;
    fl_exp[1] = 4'b00;
    fl_exp[2] = 4'b00;
    fl_exp[3] = 4'b01;
    enq_if.valid = 1'b1;
    deq_if.ready = 1'b1;
    repeat_i     = 1'b0;
    for (int b = 0; b < 4; b++) begin
      set_req(PUT_FULL, 4'd4, 26'h0004000,
              32'(b));
      #1;
      checks++;
      if ({deq_first_o, deq_last_o} !==
            fl_exp[b][1:0] ||
          beat_cnt_o !== 8'(b)) begin
        errors++;
        $display("FAIL burst_b%0d got=%b%b/%0d exp=%b/%0d",
                 b, deq_first_o, deq_last_o,
                 beat_cnt_o, fl_exp[b][1:0], b);
      end
      tick;
    end
    checks++;
    if (beat_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL burst_wrap got=%0d exp=0",
               beat_cnt_o);
    end
    set_req(GET, 4'd4, 26'h0004100, 32'h0);
    #1;
    checks++;
    if (deq_first_o !== 1'b1 ||
        deq_last_o !== 1'b1) begin
      errors++;
      $display("FAIL burst_get got=%b%b exp=11",
               deq_first_o, deq_last_o);
    end
    tick;
    set_req(PUT_FULL, 4'd1, 26'h0004200, 32'h0);
    #1;
    checks++;
    if (deq_first_o !== 1'b1 ||
        deq_last_o !== 1'b1) begin
      errors++;
      $display("FAIL burst_sub got=%b%b exp=11",
               deq_first_o, deq_last_o);
    end
    tick;
    set_req(PUT_PARTIAL, 4'd3, 26'h0004300, 32'h0);
    #1;
    checks++;
    if (deq_first_o !== 1'b1 ||
        deq_last_o !== 1'b0) begin
      errors++;
      $display("FAIL pp_b0 got=%b%b exp=10",
               deq_first_o, deq_last_o);
    end
    tick;
    checks++;
    if (deq_first_o !== 1'b0 ||
        deq_last_o !== 1'b1) begin
      errors++;
      $display("FAIL pp_b1 got=%b%b exp=01",
               deq_first_o, deq_last_o);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    set_req(PUT_FULL, 4'd3, 26'h0005000, 32'h0);
    enq_if.valid = 1'b1;
    deq_if.ready = 1'b1;
    repeat_i     = 1'b1;
    tick;
    checks++;
    if (full_o !== 1'b1 ||
        beat_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL mid_setup got=%b/%0d exp=1/1",
               full_o, beat_cnt_o);
    end
    set_req(GET, 4'd2, 26'h0006000, 32'h0);
    reset_n = 1'b0;
    tick;
    reset_n  = 1'b1;
    repeat_i = 1'b0;
    #1;
    checks++;
    if (full_o !== 1'b0 ||
        beat_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL mid_clear got=%b/%0d exp=0/0",
               full_o, beat_cnt_o);
    end
    checks++;
    if (deq_if.bits.address !== 26'h0006000 ||
        deq_first_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pass got=%h/%b exp=6000/1",
               deq_if.bits.address, deq_first_o);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    hs_cnt = 0;
    test_reset;
    test_pass;
    test_backpressure;
    test_repeat;
    test_burst;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_a_repeater.md
Name: tl_a_repeater

Overview:
- Single-entry TileLink-UL A-channel repeater that sits directly upstream of the A-channel protocol monitor and downstream fabric port.
- Normally a zero-latency pass-through. When the downstream fragmenter asserts `repeat` on a handshake, the block captures that request and re-presents it until a non-repeat handshake.
- Exports `full` plus first/last beat tracking, which the monitor uses to qualify burst and repeat checks.

Parameters:
- ADDR_W, 26, address width
- SOURCE_W, 5, source ID width
- SIZE_W, 4, log2(bytes) size field width
- DATA_W, 32, data width; BEAT_BYTES = DATA_W/8
- CNT_W, 8, beat counter width; must satisfy 2^CNT_W >= 2^(2^SIZE_W-1)/BEAT_BYTES for the sizes in use

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- enq_valid  in  1  upstream request valid
- enq_ready  out  1  upstream request ready
- enq_opcode  in  3  A opcode
- enq_param  in  3  A param
- enq_size  in  SIZE_W  log2 transfer bytes
- enq_source  in  SOURCE_W  source ID
- enq_address  in  ADDR_W  byte address
- enq_mask  in  DATA_W/8  byte mask
- enq_data  in  DATA_W  write data
- enq_corrupt  in  1  corrupt flag
- deq_valid  out  1  downstream valid
- deq_ready  in  1  downstream ready
- deq_opcode, deq_param, deq_size, deq_source, deq_address, deq_mask, deq_data, deq_corrupt  out  (widths match enq_*)  presented request
- repeat  in  1  hold the current request for re-issue; sampled only on a deq handshake
- full  out  1  a saved request is being replayed
- deq_first  out  1  the presented beat is the first beat of a message
- deq_last  out  1  the presented beat is the last beat of a message

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - full=0 and beat counter=0.
  - Saved payload registers are don't-care and need no reset.
  - Outputs after reset: deq_valid=enq_valid, enq_ready=deq_ready, deq_first=1.
- Combinational rules:
  - enq_ready = deq_ready & ~full
  - deq_valid = enq_valid | full
  - deq_* = full ? saved_* : enq_*
- Latency: 0 cycles when empty. There is no internal queueing beyond the one saved entry.
- Handshakes:
  - enq_fire = enq_valid & enq_ready
  - deq_fire = deq_valid & deq_ready
  - enq_fire implies deq_fire.
- State transitions, at each clock edge:
  - EMPTY -> FULL when enq_fire & repeat; saved_* <= enq_*.
  - FULL -> FULL when deq_fire & repeat; saved_* unchanged.
  - FULL -> EMPTY when deq_fire & ~repeat.
  - All other cycles: hold state.
  - `repeat` is ignored when deq_fire=0.
- Beat counting:
  - Data opcodes are PutFull=0 and PutPartial=1; every other opcode is a single beat.
  - beats = has_data ? max(1, 2^size / BEAT_BYTES) : 1
  - beats is computed from deq_size and deq_opcode.
  - Counter increments on deq_fire and wraps to 0 on the last beat.
  - deq_first = (cnt==0); deq_last = (cnt==beats-1).
  - Single-beat messages have first=last=1.
- Repeat within a burst: each beat is counted normally, because a replayed beat is a distinct downstream beat.
- Reset mid-operation: synchronous reset clears full and cnt on that same edge, regardless of deq_fire or repeat.
- Stalls: while deq_ready=0, all outputs remain stable (saved path) or track enq_* (pass-through path). Upstream is responsible for stability on the pass-through path.

Decomposition:
- Shared package tl_pkg holds:
  - opcode constants: PUT_FULL=0, PUT_PARTIAL=1, ARITH=2, LOGIC=3, GET=4, HINT=5
  - tl_a_t packed struct, parameterised by widths via localparams
  - has_data() function
  - num_beats() function
- One sub-module, tl_beat_counter: inputs fire, size, opcode; outputs first, last, cnt. It is reused by D-channel stages.

Test Plan:
- Pass-through: enq_valid=1, opcode=4, address=0x0001000, deq_ready=1, repeat=0.
  - deq_* equals enq_* in the same cycle; full stays 0; first=last=1.
- Backpressure: deq_ready=0 for 3 cycles, then 1.
  - enq_ready=0 during the stall; one handshake on the release cycle; no duplicate.
- Repeat x3: Get to 0x0002000 with repeat=1 on 3 consecutive deq fires, then repeat=0.
  - full=1 for 3 cycles; enq_ready=0; deq_address stays 0x0002000 while enq_address changes to 0x0003000.
  - On the 4th fire, full returns to 0.
- Multi-beat PutFull, size=4 (16B, 4 beats), consecutive fires.
  - Beat 0: first=1. Beat 3: last=1. Counter then wraps to 0.
  - A following Get shows first=last=1.
- Reset mid-repeat: full=1, then reset_n=0 for 1 cycle while deq_ready=1 and repeat=1.
  - Next cycle: full=0, cnt=0, deq_* follows enq_*.
